// File: rtl/oled_spi_receiver.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : oled_spi_receiver
// Purpose : Display-side receiver for a 4-wire write-only SPI display link.
//           The link is oversampled on clk_i, MSB-first bytes are deserialised
//           and tagged as command (DnC = 0) or data (DnC = 1), then buffered
//           and presented on a valid/ready stream.
// Revision: 1.0 - initial release
//
// Build option:
//   OLED_RX_FIFO_EN  defined   -> FIFO_DEPTH-entry circular byte buffer
//                    undefined -> single holding register (FIFO_DEPTH ignored)
//
// Parameters:
//   SYNC_STAGES  synchroniser flops per link input (>= 2)
//   FIFO_DEPTH   buffer entries, power of 2, >= 2 (FIFO build only)
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_i              asynchronous active-high reset
//   sclk_i             link serial clock (asynchronous)
//   ncs_i              link chip select, active low (asynchronous)
//   dnc_i              link data/not-command flag (asynchronous)
//   sdin_i             link serial data, MSB first (asynchronous)
//   rx_data_o   [7:0]  byte at the head of the buffer
//   rx_dnc_o           DnC captured with that byte
//   rx_valid_o         head entry valid
//   rx_ready_i         consumer accepts head when rx_valid_o && rx_ready_i
//   overflow_o         sticky: a byte was dropped because the buffer was full
//   clear_overflow_i   synchronous clear of overflow_o (a same-cycle set wins)
//   frame_abort_o      one-cycle pulse: nCS rose with a partial byte pending
// ============================================================================
module oled_spi_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sclk_i,
  input  logic       ncs_i,
  input  logic       dnc_i,
  input  logic       sdin_i,
  output logic [7:0] rx_data_o,
  output logic       rx_dnc_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       overflow_o,
  input  logic       clear_overflow_i,
  output logic       frame_abort_o
);

  // --------------------------------------------------------------------------
  // Input synchronisers, reset to the idle link state
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic [SYNC_STAGES-1:0] dnc_sync_q;
  logic [SYNC_STAGES-1:0] sdin_sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      dnc_sync_q  <= '0;
      sdin_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_i};
      dnc_sync_q  <= {dnc_sync_q[SYNC_STAGES-2:0], dnc_i};
      sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin_i};
    end
  end

  logic w_sclk_s;
  logic w_ncs_s;
  assign w_sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign w_ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Edge detection. The qualified SCLK rise is registered together with the
  // SDIN/DnC values seen in the same cycle, so data is taken from the same
  // clk_i sample that first saw SCLK high.
  // --------------------------------------------------------------------------
  logic sclk_dly_q;
  logic ncs_dly_q;
  logic rise_q;
  logic ncs_rise_q;
  logic bit_q;
  logic dnc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_dly_q <= 1'b0;
      ncs_dly_q  <= 1'b1;
      rise_q     <= 1'b0;
      ncs_rise_q <= 1'b0;
      bit_q      <= 1'b0;
      dnc_q      <= 1'b0;
    end else begin
      sclk_dly_q <= w_sclk_s;
      ncs_dly_q  <= w_ncs_s;
      rise_q     <= w_sclk_s & ~sclk_dly_q & ~w_ncs_s;
      ncs_rise_q <= w_ncs_s & ~ncs_dly_q;
      bit_q      <= sdin_sync_q[SYNC_STAGES-1];
      dnc_q      <= dnc_sync_q[SYNC_STAGES-1];
    end
  end

  // --------------------------------------------------------------------------
  // Deserialiser. Only the 7 older bits are stored; the 8th bit is appended
  // directly when the completed byte is handed to the buffer stage.
  // --------------------------------------------------------------------------
  logic [2:0] cnt_q,       cnt_d;
  logic [6:0] shift_q,     shift_d;
  logic       push_q,      push_d;
  logic [8:0] push_data_q, push_data_d;
  logic       abort_q,     abort_d;

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    abort_d     = 1'b0;
    if (ncs_rise_q) begin
      abort_d = (cnt_q != 3'd0);
      cnt_d   = 3'd0;
    end else if (rise_q) begin
      shift_d = {shift_q[5:0], bit_q};
      cnt_d   = cnt_q + 3'd1;          // wraps to 0 after the 8th bit
      if (cnt_q == 3'd7) begin
        push_d      = 1'b1;
        push_data_d = {dnc_q, shift_q, bit_q};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      push_q      <= 1'b0;
      push_data_q <= 9'd0;
      abort_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      abort_q     <= abort_d;
    end
  end

  assign frame_abort_o = abort_q;

  // --------------------------------------------------------------------------
  // Byte buffer
  // --------------------------------------------------------------------------
  logic w_pop;
  logic w_drop;

`ifdef OLED_RX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             w_full;
  logic             w_wr;

  assign w_full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign w_pop  = rx_valid_o & rx_ready_i;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign w_wr   = push_q & (~w_full | w_pop);
  assign w_drop = push_q & w_full & ~w_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (w_wr && !w_pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!w_wr && w_pop) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 9'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) mem_q[wr_ptr_q] <= push_data_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rx_valid_o = (count_q != '0);
  assign {rx_dnc_o, rx_data_o} = mem_q[rd_ptr_q];
`else
  logic [8:0] hold_q,  hold_d;
  logic       valid_q, valid_d;
  logic       w_wr;

  // FIFO_DEPTH has no effect in the single-register build.
  if (FIFO_DEPTH < 2) begin : g_depth_unused
  end

  assign w_pop  = valid_q & rx_ready_i;
  // A byte completing alongside a pop replaces the popped entry.
  assign w_wr   = push_q & (~valid_q | w_pop);
  assign w_drop = push_q & valid_q & ~w_pop;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (w_wr) begin
      hold_d  = push_data_q;
      valid_d = 1'b1;
    end else if (w_pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q  <= 9'd0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign rx_valid_o = valid_q;
  assign {rx_dnc_o, rx_data_o} = hold_q;
`endif

  // --------------------------------------------------------------------------
  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  // --------------------------------------------------------------------------
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = w_drop | (overflow_q & ~clear_overflow_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: doc/oled_spi_receiver.md
# oled_spi_receiver

Display-side receiver for the cycle computer's 4-wire write-only SPI display link: SCLK, nCS, DnC and SDIN.
It oversamples the link on the system clock, deserialises MSB-first bytes and tags each byte as command or data.
Bytes are buffered and presented on a valid/ready stream.
It sits behind the display pads in the display/emulator chip and decodes what the computer core's display driver transmits.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on each link input (minimum 2).
- FIFO_DEPTH, 4: byte buffer entries; power of 2, at least 2. Used only when OLED_RX_FIFO_EN is defined.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- SCLK  in  1  link serial clock; asynchronous to Clock.
- nCS  in  1  link chip select, active low; asynchronous.
- DnC  in  1  link data/not-command flag; asynchronous.
- SDIN  in  1  link serial data, MSB first; asynchronous.
- RxData  out  8  received byte at the head of the buffer.
- RxDnC  out  1  DnC captured with that byte (1 = data, 0 = command).
- RxValid  out  1  head entry is valid.
- RxReady  in  1  consumer accepts the head entry when RxValid && RxReady.
- Overflow  out  1  sticky flag: a byte was dropped because the buffer was full.
- ClearOverflow  in  1  synchronous clear of Overflow.
- FrameAbort  out  1  one-cycle pulse: nCS rose with a partial byte in progress.

## Operation
- SCLK, nCS, DnC and SDIN each pass through SYNC_STAGES flops. One further register on synchronised SCLK provides edge detection.
- A rising edge is synchronised SCLK = 1 while its delayed copy = 0. Edges are acted on only when synchronised nCS = 0. Falling edges are ignored.
- On each qualified rising edge, synchronised SDIN shifts into an 8-bit shift register at bit 0 (MSB arrives first), and the 3-bit bit counter increments.
- On the edge that completes bit 8, {DnC, byte} is pushed into the buffer and the bit counter wraps to 0. DnC is the synchronised value sampled on that 8th edge.
- When synchronised nCS goes high:
  - If the bit counter ≠ 0: the partial byte is discarded, the counter returns to 0, FrameAbort pulses for 1 cycle and nothing is pushed.
  - If the bit counter = 0: no pulse.
- Buffer full and a push arrives with no pop that cycle: the byte is dropped and Overflow is set. Buffer contents are unchanged.
- Push and pop in the same cycle while full: both are performed, nothing is dropped, and Overflow is not set.
- Setting and clearing Overflow in the same cycle: set wins.
- RxData and RxDnC hold the head entry while RxValid = 1 and RxReady = 0. Their values are don't-care while RxValid = 0.
- Pointer arithmetic is modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - RxValid = 0, Overflow = 0, FrameAbort = 0, RxData = 8'h00, RxDnC = 0.
  - Synchronisers reset to idle: nCS = 1, SCLK = 0, DnC = 0, SDIN = 0.
  - Bit counter = 0, buffer empty.
- Reset asserted mid-byte or mid-frame discards all partial and buffered state. There is no FrameAbort pulse on reset exit.
- Link constraints: SCLK high and low phases are each ≥ 2 Clock periods. SDIN and DnC are stable from 1 Clock period before to 1 Clock period after the SCLK rising edge. nCS falls ≥ 2 Clock periods before the first SCLK rise.
- Latency: RxValid rises SYNC_STAGES + 2 Clock cycles after the 8th SCLK rise is registered by the first synchroniser stage, given an empty buffer.
- FrameAbort rises SYNC_STAGES + 1 cycles after nCS is registered high by the first stage.
- A pop takes effect at the accepting edge. The next entry, if any, is presented in the following cycle with no bubble.

## Configuration
- OLED_RX_FIFO_EN defined: a FIFO_DEPTH-entry circular buffer as described above.
- OLED_RX_FIFO_EN undefined:
  - The buffer is a single holding register; FIFO_DEPTH is ignored.
  - Full = RxValid.
  - A byte completing while RxValid = 1 and RxReady = 0 is dropped and sets Overflow.
  - A byte completing in the same cycle as a pop replaces the popped entry.

## Test plan
- Frame with nCS low, DnC = 0, byte 8'hAF, RxReady = 1 → one RxValid pulse with RxData = 8'hAF and RxDnC = 0, at the latency above.
- Frame with command 8'h81, then DnC = 1 and data 8'h7F, 8'h00 in one nCS window → three entries in order: (0,81), (1,7F), (1,00). FrameAbort never asserts.
- nCS raised after 5 bits, then a full byte 8'h3C → FrameAbort pulses once and only 8'h3C is received.
- RxReady = 0 while 5 bytes 8'h01..8'h05 are sent → with FIFO_EN (depth 4), 01..04 are held, 05 is dropped and Overflow = 1. Without FIFO_EN, 01 is held, 02..05 are dropped and Overflow = 1. ClearOverflow then returns Overflow to 0.
- Buffer full; a byte completes in the same cycle as an RxReady pop → nothing is dropped, Overflow stays 0, and order is preserved.
- Reset asserted after 4 bits of 8'hFF, then released and 8'h5A sent → only 8'h5A is received, with no FrameAbort pulse.
